// File: rtl/acc_seq_ctrl_pkg.sv
// Shared definitions for the accumulator sequencer: state encoding and default widths.
package acc_seq_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/acc_dp.sv
// Accumulator datapath: WIDTH-bit register that either loads D or adds D to itself.
module acc_dp
    import acc_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             ldacc,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             carry
);

    logic [WIDTH:0] sum;

    assign sum   = {1'b0, Q} + {1'b0, D};
    assign carry = sum[WIDTH];

    // clr is the empty-run clear; it is the only way Q changes without en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q <= '0;
        end else if (clr) begin
            Q <= '0;
        end else if (en) begin
            Q <= ldacc ? D : sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/acc_seq_ctrl.sv
// Sequencer that streams n_ops operands into the accumulator and flags completion/overflow.
module acc_seq_ctrl
    import acc_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_ops,
    input  logic [WIDTH-1:0] D,
    input  logic             op_valid,
    output logic             op_ready,
    output logic [WIDTH-1:0] Q,
    output logic             ldacc,
    output logic             en,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             hs;
    logic             last;
    logic             clr;
    logic             carry;

    assign hs    = op_valid & op_ready;
    assign en    = hs;
    assign ldacc = hs & (state == LOAD);
    assign last  = (cnt == CNT_W'(1));
    assign clr   = (state == IDLE) & start & (n_ops == '0);

    // Moore outputs are registered alongside the state so they track it exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ovf      <= 1'b0;
            op_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ovf  <= 1'b0;
                        busy <= 1'b1;
                        if (n_ops != '0) begin
                            cnt      <= n_ops;
                            state    <= LOAD;
                            op_ready <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                LOAD, ACC: begin
                    if (hs) begin
                        cnt <= cnt - CNT_W'(1);
                        if (state == ACC) begin
                            ovf <= ovf | carry;
                        end
                        if (last) begin
                            state    <= DONE;
                            op_ready <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    op_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    acc_dp #(
        .WIDTH (WIDTH)
    ) u_acc_dp (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (en),
        .ldacc (ldacc),
        .D     (D),
        .Q     (Q),
        .carry (carry)
    );

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Directed self-checking bench for acc_seq_ctrl.
module tb_acc_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] n_ops;
    logic [7:0] D;
    logic       op_valid;
    logic       op_ready;
    logic [7:0] Q;
    logic       ldacc;
    logic       en;
    logic       busy;
    logic       done;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    acc_seq_ctrl #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .n_ops    (n_ops),
        .D        (D),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .Q        (Q),
        .ldacc    (ldacc),
        .en       (en),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; n_ops = '0; D = '0; op_valid = 1'b0;
        #2;
        chk("rst_q", Q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", op_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_en", en, 0);
        chk("rst_ldacc", ldacc, 0);
        chk("rst_ovf", ovf, 0);
        tick();
        rst = 1'b0;
        tick();

        // Basic sum 1+2+3
        start = 1'b1; n_ops = 4'd3; D = 8'd1; op_valid = 1'b1;
        #1 chk("sum_idle_en", en, 0);
        tick(); start = 1'b0; #1;
        chk("sum_load_ready", op_ready, 1);
        chk("sum_load_busy", busy, 1);
        chk("sum_load_en", en, 1);
        chk("sum_load_ldacc", ldacc, 1);
        tick(); D = 8'd2; #1;
        chk("sum_q1", Q, 1);
        chk("sum_acc1_en", en, 1);
        chk("sum_acc1_ldacc", ldacc, 0);
        tick(); D = 8'd3; #1;
        chk("sum_q3", Q, 3);
        chk("sum_acc2_en", en, 1);
        chk("sum_acc2_ldacc", ldacc, 0);
        chk("sum_acc2_done", done, 0);
        tick(); op_valid = 1'b0; #1;
        chk("sum_done", done, 1);
        chk("sum_q6", Q, 6);
        chk("sum_ovf", ovf, 0);
        chk("sum_done_ready", op_ready, 0);
        tick();
        chk("sum_idle_done", done, 0);
        chk("sum_idle_busy", busy, 0);
        chk("sum_idle_q", Q, 6);

        // Overflow: 200 + 100 = 300 -> 44 with carry
        start = 1'b1; n_ops = 4'd2; D = 8'd200; op_valid = 1'b1;
        tick(); start = 1'b0;
        tick(); D = 8'd100; #1;
        chk("ovf_q200", Q, 200);
        chk("ovf_mid", ovf, 0);
        tick(); op_valid = 1'b0; #1;
        chk("ovf_q44", Q, 44);
        chk("ovf_set", ovf, 1);
        chk("ovf_done", done, 1);
        tick();
        chk("ovf_sticky", ovf, 1);
        start = 1'b1; n_ops = 4'd1; D = 8'd5; op_valid = 1'b1;
        tick(); start = 1'b0; #1;
        chk("ovf_clr_on_start", ovf, 0);
        tick(); op_valid = 1'b0; #1;
        chk("one_q5", Q, 5);
        chk("one_done", done, 1);
        chk("one_ovf", ovf, 0);
        tick();

        // Empty run: sum cleared, op_ready never asserts
        start = 1'b1; n_ops = 4'd0; D = 8'd9; op_valid = 1'b1;
        #1 chk("empty_idle_en", en, 0);
        tick(); start = 1'b0; #1;
        chk("empty_done", done, 1);
        chk("empty_q", Q, 0);
        chk("empty_ready", op_ready, 0);
        chk("empty_en", en, 0);
        tick();
        chk("empty_after_ready", op_ready, 0);
        chk("empty_after_done", done, 0);
        chk("empty_after_q", Q, 0);
        op_valid = 1'b0;

        // Stalls between operands, with start pulses ignored while busy
        start = 1'b1; n_ops = 4'd2; D = 8'd10; op_valid = 1'b1;
        tick(); start = 1'b0;
        tick(); op_valid = 1'b0; start = 1'b1; n_ops = 4'd5; #1;
        chk("stall_q10_a", Q, 10);
        chk("stall_en_a", en, 0);
        tick(); start = 1'b0; #1;
        chk("stall_q10_b", Q, 10);
        chk("stall_ready", op_ready, 1);
        chk("stall_busy", busy, 1);
        tick(); start = 1'b1; #1;
        chk("stall_q10_c", Q, 10);
        chk("stall_en_c", en, 0);
        tick(); start = 1'b0; D = 8'd20; op_valid = 1'b1; #1;
        chk("stall_resume_en", en, 1);
        tick(); op_valid = 1'b0; #1;
        chk("stall_done", done, 1);
        chk("stall_q30", Q, 30);
        tick();

        // Max count: 15 x 17 = 255
        start = 1'b1; n_ops = 4'd15; D = 8'd17; op_valid = 1'b1;
        tick(); start = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            chk("max_no_done", done, 0);
        end
        tick(); op_valid = 1'b0; #1;
        chk("max_done", done, 1);
        chk("max_q255", Q, 255);
        chk("max_ovf", ovf, 0);
        tick();
        start = 1'b1; n_ops = 4'd1; D = 8'd1; op_valid = 1'b1;
        tick(); start = 1'b0; #1;
        chk("restart_ldacc", ldacc, 1);
        tick(); op_valid = 1'b0; #1;
        chk("restart_done", done, 1);
        chk("restart_q1", Q, 1);
        tick();

        // Reset mid-run, then a clean run
        start = 1'b1; n_ops = 4'd3; D = 8'd7; op_valid = 1'b1;
        tick(); start = 1'b0;
        tick();
        chk("midrst_pre_q", Q, 7);
        #1 rst = 1'b1;
        #1;
        chk("midrst_q", Q, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", op_ready, 0);
        chk("midrst_en", en, 0);
        tick(); rst = 1'b0; op_valid = 1'b0;
        tick();
        start = 1'b1; n_ops = 4'd2; D = 8'd4; op_valid = 1'b1;
        tick(); start = 1'b0;
        tick(); D = 8'd5;
        tick(); op_valid = 1'b0; #1;
        chk("post_rst_done", done, 1);
        chk("post_rst_q9", Q, 9);
        tick();
        chk("post_rst_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
